// File: rtl/two_of_five_ctrl_if.sv
// Serial 2-of-5 receiver bus: bit stream and statistics control in, decode results out.
// The master side drives the bit stream; the slave side is the decoder.
interface two_of_five_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             in;
    logic             in_en;
    logic             clear_stats;
    logic             valid;
    logic             error;
    logic [3:0]       digit;
    logic             timeout;
    logic             busy;
    logic [CNT_W-1:0] good_count;
    logic [CNT_W-1:0] bad_count;

    modport master (
        output in, in_en, clear_stats,
        input  valid, error, digit, timeout, busy, good_count, bad_count
    );

    modport slave (
        input  in, in_en, clear_stats,
        output valid, error, digit, timeout, busy, good_count, bad_count
    );
endinterface

// File: rtl/two_of_five_ctrl.sv
// Serial 2-of-5 decimal decoder (weights 7-4-2-1-0, bit0 first) with idle abort
// and saturating good/bad nibble statistics.
module two_of_five_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    two_of_five_ctrl_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q;
    logic [1:0]       ones_cnt_q;
    logic [3:0]       shreg_q;
    logic [7:0]       idle_cnt_q;
    logic             timeout_q;
    logic             busy_q;
    logic [CNT_W-1:0] good_q;
    logic [CNT_W-1:0] bad_q;

    logic bit_inc, bit_clr, ones_inc, ones_clr, shift_en, idle_inc, idle_clr;
    logic fifth, abort;
    logic valid_c, error_c;
    logic [2:0] ones_total;
    logic [3:0] digit_c;

    // Control points for the datapath; the 5th bit and the idle abort both return to IDLE.
    always_comb begin
        state_d  = state_q;
        bit_inc  = 1'b0;
        bit_clr  = 1'b0;
        ones_inc = 1'b0;
        ones_clr = 1'b0;
        shift_en = 1'b0;
        idle_inc = 1'b0;
        idle_clr = 1'b0;
        fifth    = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            IDLE: begin
                idle_clr = 1'b1;
                if (bus.in_en) begin
                    bit_inc  = 1'b1;
                    ones_inc = bus.in;
                    shift_en = 1'b1;
                    state_d  = COLLECT;
                end
            end
            COLLECT, DISCARD: begin
                if (bus.in_en) begin
                    idle_clr = 1'b1;
                    if (bit_cnt_q == 3'd4) begin
                        fifth    = 1'b1;
                        bit_clr  = 1'b1;
                        ones_clr = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        bit_inc  = 1'b1;
                        ones_inc = bus.in;
                        shift_en = 1'b1;
                        if (state_q == COLLECT && bus.in && ones_cnt_q == 2'd2)
                            state_d = DISCARD;
                    end
                end else if (idle_cnt_q == IDLE_LAST) begin
                    abort    = 1'b1;
                    bit_clr  = 1'b1;
                    ones_clr = 1'b1;
                    idle_clr = 1'b1;
                    state_d  = IDLE;
                end else begin
                    idle_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ones_total = {1'b0, ones_cnt_q} + {2'b00, bus.in};
    assign valid_c    = fifth && (state_q == COLLECT) && (ones_total == 3'd2) && !reset;
    assign error_c    = fifth && !valid_c && !reset;

    always_comb begin
        digit_c = 4'd0;
        if (valid_c) begin
            unique case ({bus.in, shreg_q})
                5'b00011: digit_c = 4'd1;
                5'b00101: digit_c = 4'd2;
                5'b00110: digit_c = 4'd3;
                5'b01001: digit_c = 4'd4;
                5'b01010: digit_c = 4'd5;
                5'b01100: digit_c = 4'd6;
                5'b10001: digit_c = 4'd7;
                5'b10010: digit_c = 4'd8;
                5'b10100: digit_c = 4'd9;
                default:  digit_c = 4'd0;
            endcase
        end
    end

    // The shift register fills from the top so bit0 ends up in shreg_q[0] after four bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            ones_cnt_q <= 2'd0;
            shreg_q    <= 4'd0;
            idle_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
            busy_q     <= 1'b0;
            good_q     <= '0;
            bad_q      <= '0;
        end else begin
            state_q   <= state_d;
            timeout_q <= abort;
            busy_q    <= (state_d != IDLE);
            if (bit_clr)
                bit_cnt_q <= 3'd0;
            else if (bit_inc)
                bit_cnt_q <= bit_cnt_q + 3'd1;
            if (ones_clr)
                ones_cnt_q <= 2'd0;
            else if (ones_inc && ones_cnt_q != 2'd3)
                ones_cnt_q <= ones_cnt_q + 2'd1;
            if (shift_en)
                shreg_q <= {bus.in, shreg_q[3:1]};
            if (idle_clr)
                idle_cnt_q <= 8'd0;
            else if (idle_inc)
                idle_cnt_q <= idle_cnt_q + 8'd1;
            if (bus.clear_stats) begin
                good_q <= '0;
                bad_q  <= '0;
            end else begin
                if (valid_c && good_q != {CNT_W{1'b1}})
                    good_q <= good_q + 1'b1;
                if (error_c && bad_q != {CNT_W{1'b1}})
                    bad_q <= bad_q + 1'b1;
            end
        end
    end

    assign bus.valid      = valid_c;
    assign bus.error      = error_c;
    assign bus.digit      = digit_c;
    assign bus.timeout    = timeout_q;
    assign bus.busy       = busy_q && !reset;
    assign bus.good_count = good_q;
    assign bus.bad_count  = bad_q;
endmodule

// File: tb/tb_two_of_five_ctrl.sv
// Bench for two_of_five_ctrl: a nibble-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_two_of_five_ctrl;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 8;
    localparam int MAXC    = 255;

    logic clk;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    two_of_five_ctrl_if #(.CNT_W(CNT_W)) bus ();

    two_of_five_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the bits of the current nibble, idle gap length and totals.
    int  mBits = 0;
    bit  mNib[4];
    int  mIdle = 0;
    bit  mTmo = 1'b0;
    int  mGood = 0;
    int  mBad = 0;
    bit  modelReady = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // What this cycle's combinational outputs must be, from the popcount and weight rules.
    function automatic void expectComb(output bit v, output bit e, output logic [3:0] d);
        int ones;
        int sum;
        v = 1'b0;
        e = 1'b0;
        d = 4'd0;
        if (!reset && bus.in_en && mBits == 4) begin
            ones = int'(bus.in);
            for (int i = 0; i < 4; i++) ones += int'(mNib[i]);
            sum = 7 * int'(bus.in) + 4 * int'(mNib[3]) + 2 * int'(mNib[2]) + int'(mNib[1]);
            if (ones == 2) begin
                v = 1'b1;
                d = (sum == 11) ? 4'd0 : 4'(sum);
            end else begin
                e = 1'b1;
            end
        end
    endfunction

    always @(posedge clk) begin
        bit v, e;
        logic [3:0] d;
        expectComb(v, e, d);
        if (reset) begin
            mBits = 0; mIdle = 0; mTmo = 1'b0; mGood = 0; mBad = 0;
            modelReady = 1'b1;
        end else begin
            mTmo = 1'b0;
            if (bus.clear_stats) begin
                mGood = 0;
                mBad  = 0;
            end else begin
                if (v && mGood < MAXC) mGood++;
                if (e && mBad < MAXC) mBad++;
            end
            if (bus.in_en) begin
                mIdle = 0;
                if (mBits == 4) mBits = 0;
                else begin
                    mNib[mBits] = bus.in;
                    mBits++;
                end
            end else if (mBits > 0) begin
                mIdle++;
                if (mIdle == TIMEOUT) begin
                    mBits = 0;
                    mIdle = 0;
                    mTmo  = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit v, e;
        logic [3:0] d;
        if (modelReady) begin
            expectComb(v, e, d);
            checkOutput("valid", 32'(bus.valid), 32'(v));
            checkOutput("error", 32'(bus.error), 32'(e));
            checkOutput("digit", 32'(bus.digit), 32'(d));
            checkOutput("busy", 32'(bus.busy), 32'(!reset && mBits > 0));
            checkOutput("timeout", 32'(bus.timeout), 32'(mTmo));
            checkOutput("good_count", 32'(bus.good_count), 32'(mGood));
            checkOutput("bad_count", 32'(bus.bad_count), 32'(mBad));
        end
    end

    task automatic applyStimulus(input bit b, input bit en, input bit clr, input bit rst);
        bus.in          = b;
        bus.in_en       = en;
        bus.clear_stats = clr;
        reset           = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    // Sends one nibble bit0 first, with optional idle gaps, and pins the 5th-bit outputs.
    task automatic sendNibble(input logic [4:0] nib, input int gap, input bit clrOn5th,
                              input bit expV, input logic [3:0] expD, input string tag);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) idleCycles(gap);
            applyStimulus(nib[i], 1'b1, clrOn5th && (i == 4), 1'b0);
            if (i == 4) begin
                checkOutput({tag, " valid"}, 32'(bus.valid), 32'(expV));
                checkOutput({tag, " error"}, 32'(bus.error), 32'(!expV));
                checkOutput({tag, " digit"}, 32'(bus.digit), 32'(expD));
            end
            tick();
        end
    endtask

    logic [4:0] codes [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01001, 5'b01010,
                               5'b01100, 5'b10001, 5'b10010, 5'b10100, 5'b11000};
    logic [3:0] digits [10] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0};

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset good", 32'(bus.good_count), 32'd0);
        checkOutput("reset timeout", 32'(bus.timeout), 32'd0);
        idleCycles(2);

        sendNibble(5'b00011, 0, 1'b0, 1'b1, 4'd1, "nib 11000 first");
        checkOutput("good after first", 32'(bus.good_count), 32'd1);
        checkOutput("bad after first", 32'(bus.bad_count), 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 10; k++)
            sendNibble(codes[k], 0, 1'b0, 1'b1, digits[k], "code");
        checkOutput("good after ten", 32'(bus.good_count), 32'd10);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        sendNibble(5'b00111, 0, 1'b0, 1'b0, 4'd0, "three ones");
        checkOutput("bad after 3 ones", 32'(bus.bad_count), 32'd1);
        sendNibble(5'b00000, 0, 1'b0, 1'b0, 4'd0, "zero ones");
        checkOutput("bad after 0 ones", 32'(bus.bad_count), 32'd2);

        // Three bits then a long gap: abort in the 16th idle cycle.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("clear mid-nibble busy", 32'(bus.busy), 32'd1);
        checkOutput("clear mid-nibble bad", 32'(bus.bad_count), 32'd0);
        idleCycles(14);
        checkOutput("pre-abort busy", 32'(bus.busy), 32'd1);
        checkOutput("pre-abort timeout", 32'(bus.timeout), 32'd0);
        idleCycles(1);
        checkOutput("abort timeout", 32'(bus.timeout), 32'd1);
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        idleCycles(1);
        checkOutput("timeout one pulse", 32'(bus.timeout), 32'd0);
        sendNibble(5'b00110, 0, 1'b0, 1'b1, 4'd3, "after abort");

        sendNibble(5'b10001, 15, 1'b0, 1'b1, 4'd7, "gap 15");
        checkOutput("gap good", 32'(bus.good_count), 32'd2);

        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 256; k++)
            sendNibble(5'b00011, 0, 1'b0, 1'b1, 4'd1, "saturate");
        checkOutput("good saturated", 32'(bus.good_count), 32'd255);
        sendNibble(5'b00101, 0, 1'b0, 1'b1, 4'd2, "past saturation");
        checkOutput("good stays 255", 32'(bus.good_count), 32'd255);
        sendNibble(5'b01001, 0, 1'b1, 1'b1, 4'd4, "clear with valid");
        checkOutput("clear wins", 32'(bus.good_count), 32'd0);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("in reset valid", 32'(bus.valid), 32'd0);
        checkOutput("in reset busy", 32'(bus.busy), 32'd0);
        tick();
        sendNibble(5'b11000, 0, 1'b0, 1'b1, 4'd0, "after reset");
        checkOutput("good after reset", 32'(bus.good_count), 32'd1);
        idleCycles(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
